// File: rtl/ext_pwr_gate_ctrl.sv
// Power-gate sequencer for one external domain: orders switch, isolation and
// domain reset, waiting on the synchronised switch-cell acknowledge.
module ext_pwr_gate_ctrl #(
    parameter int ISO_SETTLE  = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       target_on_i,
    output logic       switch_o,
    input  logic       switch_ack_i,
    output logic       iso_o,
    output logic       dom_rst_no,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       err_clr_i,
    output logic [2:0] state_o
);

    localparam int SCW = $clog2(ISO_SETTLE + 1);
    localparam int TCW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(ISO_SETTLE - 1);
    localparam logic [TCW-1:0] TMO_MAX     = TCW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_ISO     = 3'd1,
        ST_RST     = 3'd2,
        ST_SW_OFF  = 3'd3,
        ST_OFF     = 3'd4,
        ST_SW_ON   = 3'd5,
        ST_SETTLE  = 3'd6,
        ST_RST_REL = 3'd7
    } state_e;

    state_e         state_q, state_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           ack_meta_q, ack_s_q;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           switch_q, switch_d;
    logic           iso_q, iso_d;
    logic           dom_rst_q, dom_rst_d;
    logic           err_set;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_ON: begin
                if (!target_on_i) begin
                    state_d  = ST_ISO;
                    settle_d = '0;
                end
            end
            ST_ISO: begin
                if (settle_q == SETTLE_LAST) state_d = ST_RST;
                else                         settle_d = settle_q + 1'b1;
            end
            ST_RST: begin
                state_d = ST_SW_OFF;
                tmo_d   = '0;
            end
            ST_SW_OFF: begin
                if (!ack_s_q)              state_d = ST_OFF;
                else if (tmo_q != TMO_MAX) tmo_d   = tmo_q + 1'b1;
            end
            ST_OFF: begin
                if (target_on_i) begin
                    state_d = ST_SW_ON;
                    tmo_d   = '0;
                end
            end
            ST_SW_ON: begin
                if (ack_s_q) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_RST_REL;
                else                         settle_d = settle_q + 1'b1;
            end
            ST_RST_REL: state_d = ST_ON;
            default:    state_d = ST_ON;
        endcase

        // Error is raised on the cycle the wait counter first hits its limit; it outranks a clear.
        err_set = (tmo_d == TMO_MAX) && (tmo_q != TMO_MAX);
        if (err_set)        err_d = 1'b1;
        else if (err_clr_i) err_d = 1'b0;
        else                err_d = err_q;

        done_d = ((state_q == ST_SW_OFF) && (state_d == ST_OFF)) ||
                 ((state_q == ST_RST_REL) && (state_d == ST_ON));
        busy_d = !((state_d == ST_ON) || (state_d == ST_OFF));

        switch_d  = !((state_d == ST_SW_OFF) || (state_d == ST_OFF));
        iso_d     = (state_d != ST_ON);
        dom_rst_d = (state_d == ST_ON) || (state_d == ST_ISO) || (state_d == ST_RST_REL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ON;
            settle_q   <= '0;
            tmo_q      <= '0;
            ack_meta_q <= 1'b1;
            ack_s_q    <= 1'b1;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            switch_q   <= 1'b1;
            iso_q      <= 1'b0;
            dom_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            ack_meta_q <= switch_ack_i;
            ack_s_q    <= ack_meta_q;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            switch_q   <= switch_d;
            iso_q      <= iso_d;
            dom_rst_q  <= dom_rst_d;
        end
    end

    assign switch_o   = switch_q;
    assign iso_o      = iso_q;
    assign dom_rst_no = dom_rst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_ext_pwr_gate_ctrl.sv
// Bench for ext_pwr_gate_ctrl: random-latency switch-cell model and a timing
// model computed from the sequencing rules (settle time, latency + 3 cycles).
module tb_ext_pwr_gate_ctrl;

    localparam int S = 2;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       target = 1'b1;
    logic       err_clr = 1'b0;
    logic       ack;
    logic       switch_o, iso_o, dom_rst_no, busy_o, done_o, err_o;
    logic [2:0] state_o;
    logic [8:0] act;

    logic [31:0] hist = '1;
    int          lat = 15;
    logic        force_en = 1'b0;
    logic        force_val = 1'b0;
    logic        exp_err = 1'b0;

    int total = 0;
    int bad = 0;

    ext_pwr_gate_ctrl #(.ISO_SETTLE(S), .ACK_TIMEOUT(T)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .target_on_i(target),
        .switch_o(switch_o),
        .switch_ack_i(ack),
        .iso_o(iso_o),
        .dom_rst_no(dom_rst_no),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .err_clr_i(err_clr),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Switch cell: ack mirrors switch_o delayed by 'lat' rising edges.
    always @(posedge clk) hist <= {hist[30:0], switch_o};
    assign ack = force_en ? force_val : hist[lat-1];

    assign act = {switch_o, iso_o, dom_rst_no, busy_o, done_o, err_o, state_o};

    logic p_sw = 1'b1, p_iso = 1'b0, p_rst = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((p_iso && !iso_o && (!p_rst || !p_sw)) || (p_sw && !switch_o && !p_iso)) begin
                bad++;
                $display("[TB] FAIL ordering t=%0t got sw/iso/rst=%b%b%b from %b%b%b", $time,
                         switch_o, iso_o, dom_rst_no, p_sw, p_iso, p_rst);
            end
        end
        p_sw  = switch_o;
        p_iso = iso_o;
        p_rst = dom_rst_no;
    end

    // Expected {switch, iso, rst_n, busy, done, err, state} k edges after a power-down request.
    function automatic logic [8:0] exp_down(input int k, input int l, input logic e);
        int toff;
        logic [2:0] st;
        toff = S + l + 4;
        if (k < S)         st = 3'd1;
        else if (k == S)   st = 3'd2;
        else if (k < toff) st = 3'd3;
        else               st = 3'd4;
        return {k <= S, 1'b1, k < S, k < toff, k == toff, e, st};
    endfunction

    function automatic logic [8:0] exp_up(input int k, input int l, input logic e);
        int tset, ton;
        logic [2:0] st;
        tset = l + 3;
        ton  = l + S + 4;
        if (k < tset)          st = 3'd5;
        else if (k < tset + S) st = 3'd6;
        else if (k < ton)      st = 3'd7;
        else                   st = 3'd0;
        return {1'b1, k < ton, k >= tset + S, k < ton, k == ton, e, st};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (act !== 9'b100000000) begin
            bad++;
            $display("[TB] FAIL reset_async got=%b want=%b", act, 9'b100000000);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (act !== 9'b100000000) begin
                bad++;
                $display("[TB] FAIL reset_hold i=%0d got=%b want=%b", i, act, 9'b100000000);
            end
        end
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (act !== 9'b100000000) begin
            bad++;
            $display("[TB] FAIL reset_release_pre_edge got=%b want=%b", act, 9'b100000000);
        end
        step();
        total++;
        if (act !== 9'b101000000) begin
            bad++;
            $display("[TB] FAIL reset_first_edge got=%b want=%b", act, 9'b101000000);
        end
    endtask

    task automatic test_idle(input int n, input logic on);
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            target = on;
            step();
            e = on ? {3'b101, 2'b00, exp_err, 3'd0} : {3'b010, 2'b00, exp_err, 3'd4};
            total++;
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL idle_%s i=%0d got=%b want=%b", on ? "on" : "off", i, act, e);
            end
        end
    endtask

    task automatic test_power_down(input int l, input bit noise, input bit go_up);
        int toff;
        logic [8:0] e;
        toff = S + l + 4;
        target = 1'b0;
        for (int k = 0; k <= toff; k++) begin
            step();
            e = exp_down(k, l, exp_err);
            total++;
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL power_down lat=%0d k=%0d got=%b want=%b", l, k, act, e);
            end
            if (go_up && k >= S + 2)       target = 1'b1;
            else if (noise && k < toff)    target = 1'($urandom_range(0, 1));
            else                           target = 1'b0;
        end
    endtask

    task automatic test_power_up(input int l, input bit noise);
        int ton;
        logic [8:0] e;
        ton = l + S + 4;
        target = 1'b1;
        for (int k = 0; k <= ton; k++) begin
            step();
            e = exp_up(k, l, exp_err);
            total++;
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL power_up lat=%0d k=%0d got=%b want=%b", l, k, act, e);
            end
            if (noise && k < ton) target = 1'($urandom_range(0, 1));
            else                  target = 1'b1;
        end
    endtask

    task automatic test_power_cycle();
        for (int n = 0; n < 3; n++) begin
            lat = int'($urandom_range(3, 20));
            test_idle(24 + int'($urandom_range(0, 3)), 1'b1);
            test_power_down(lat, 1'b1, 1'b0);
            test_idle(int'($urandom_range(0, 4)), 1'b0);
            test_power_up(lat, 1'b1);
        end
    endtask

    task automatic test_timeout_down();
        int r;
        logic [8:0] e;
        r = S + T + 5;
        lat = 8;
        test_idle(24, 1'b1);
        force_val = 1'b1;
        force_en = 1'b1;
        target = 1'b0;
        for (int k = 0; k <= r + 3; k++) begin
            step();
            e = exp_down(k, r - S - 1, k >= S + 1 + T);
            total++;
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL timeout_down k=%0d got=%b want=%b", k, act, e);
            end
            if (k == r) force_en = 1'b0;
        end
        exp_err = 1'b1;
        test_idle(4, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 1'b0;
        total++;
        if (act !== 9'b010000100) begin
            bad++;
            $display("[TB] FAIL err_clear_off got=%b want=%b", act, 9'b010000100);
        end
    endtask

    task automatic test_timeout_up_clear();
        int r;
        logic [8:0] e;
        r = T + 2;
        force_val = 1'b0;
        force_en = 1'b1;
        target = 1'b1;
        for (int k = 0; k <= r + S + 4; k++) begin
            err_clr = (k == T);
            step();
            err_clr = 1'b0;
            e = exp_up(k, r, k >= T);
            total++;
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL timeout_up_set_beats_clear k=%0d got=%b want=%b", k, act, e);
            end
            if (k == r) force_en = 1'b0;
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 1'b0;
        total++;
        if (act !== 9'b101000000) begin
            bad++;
            $display("[TB] FAIL err_clear_on got=%b want=%b", act, 9'b101000000);
        end
    endtask

    task automatic test_mid_sequence();
        lat = int'($urandom_range(3, 20));
        test_idle(24, 1'b1);
        test_power_down(lat, 1'b0, 1'b1);
        test_power_up(lat, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        lat = 10;
        test_idle(24, 1'b1);
        test_power_down(lat, 1'b0, 1'b0);
        test_idle(2, 1'b0);
        target = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            e = exp_up(k, lat, exp_err);
            total++;
            if (act !== e) begin
                bad++;
                $display("[TB] FAIL pre_reset_sw_on k=%0d got=%b want=%b", k, act, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (act !== 9'b100000000) begin
            bad++;
            $display("[TB] FAIL mid_seq_reset_immediate got=%b want=%b", act, 9'b100000000);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (act !== 9'b100000000) begin
                bad++;
                $display("[TB] FAIL mid_seq_reset_hold i=%0d got=%b want=%b", i, act, 9'b100000000);
            end
        end
        #2 rst_n = 1'b1;
        step();
        total++;
        if (act !== 9'b101000000) begin
            bad++;
            $display("[TB] FAIL mid_seq_reset_release got=%b want=%b", act, 9'b101000000);
        end
        test_idle(24, 1'b1);
        test_power_down(lat, 1'b0, 1'b0);
        test_power_up(lat, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle(24, 1'b1);
        test_power_down(15, 1'b0, 1'b0);
        test_idle(3, 1'b0);
        test_power_up(15, 1'b0);
        test_power_cycle();
        test_timeout_down();
        test_timeout_up_clear();
        test_mid_sequence();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
